// File: rtl/pll_reconfig_master.sv
`default_nettype none
// ============================================================================
// Module      : pll_reconfig_master
// Description : Avalon-MM master that programs N/M/K/C0/C1 into an
//               altera_pll_reconfig mgmt port, issues START and waits for relock.
// Revision    : 1.0 - initial release
// ============================================================================
module pll_reconfig_master #(
    parameter int TIMEOUT_W = 20,
    parameter bit FRAC_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [17:0] cfg_n,
    input  logic [17:0] cfg_m,
    input  logic [31:0] cfg_k,
    input  logic [17:0] cfg_c0,
    input  logic [17:0] cfg_c1,
    output logic [5:0]  mgmt_address,
    output logic        mgmt_write,
    output logic [31:0] mgmt_writedata,
    input  logic        mgmt_waitrequest,
    input  logic        pll_locked,
    output logic        busy,
    output logic        done,
    output logic        error
);

    localparam logic [3:0] c_st_idle      = 4'd0;
    localparam logic [3:0] c_st_wr_mode   = 4'd1;
    localparam logic [3:0] c_st_wr_n      = 4'd2;
    localparam logic [3:0] c_st_wr_m      = 4'd3;
    localparam logic [3:0] c_st_wr_k      = 4'd4;
    localparam logic [3:0] c_st_wr_c0     = 4'd5;
    localparam logic [3:0] c_st_wr_c1     = 4'd6;
    localparam logic [3:0] c_st_wr_start  = 4'd7;
    localparam logic [3:0] c_st_wait_lock = 4'd8;

    localparam logic [TIMEOUT_W-1:0] c_cnt_max = '1;

    logic [3:0]           r_state, w_state_nxt, w_seq_nxt;
    logic                 r_lk_meta, r_lk_s;
    logic [17:0]          r_n, r_m, r_c0, r_c1;
    logic [31:0]          r_k;
    logic                 r_write, w_write_nxt;
    logic [5:0]           r_addr, w_addr_nxt, w_tgt_addr;
    logic [31:0]          r_data, w_data_nxt, w_tgt_data;
    logic                 r_done, w_done_nxt;
    logic                 r_error, w_error_nxt;
    logic [TIMEOUT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic                 r_seen_low, w_seen_low_nxt;
    logic                 w_load;
    logic                 w_wr_cmpl;

    assign w_wr_cmpl = r_write & ~mgmt_waitrequest;
    assign w_cnt_inc = r_cnt + TIMEOUT_W'(1);

    // State that follows the current write; from IDLE the first write is the mode write.
    always_comb begin
        case (r_state)
            c_st_wr_mode:  w_seq_nxt = c_st_wr_n;
            c_st_wr_n:     w_seq_nxt = c_st_wr_m;
            c_st_wr_m:     w_seq_nxt = FRAC_EN ? c_st_wr_k : c_st_wr_c0;
            c_st_wr_k:     w_seq_nxt = c_st_wr_c0;
            c_st_wr_c0:    w_seq_nxt = c_st_wr_c1;
            c_st_wr_c1:    w_seq_nxt = c_st_wr_start;
            c_st_wr_start: w_seq_nxt = c_st_wait_lock;
            default:       w_seq_nxt = c_st_wr_mode;
        endcase
    end

    always_comb begin
        w_tgt_addr = 6'd0;
        w_tgt_data = 32'd0;
        case (w_seq_nxt)
            c_st_wr_n:     begin w_tgt_addr = 6'd3; w_tgt_data = {14'b0, r_n}; end
            c_st_wr_m:     begin w_tgt_addr = 6'd4; w_tgt_data = {14'b0, r_m}; end
            c_st_wr_k:     begin w_tgt_addr = 6'd7; w_tgt_data = r_k; end
            c_st_wr_c0:    begin w_tgt_addr = 6'd5; w_tgt_data = {9'b0, 5'd0, r_c0}; end
            c_st_wr_c1:    begin w_tgt_addr = 6'd5; w_tgt_data = {9'b0, 5'd1, r_c1}; end
            c_st_wr_start: begin w_tgt_addr = 6'd2; w_tgt_data = 32'd1; end
            default:       begin w_tgt_addr = 6'd0; w_tgt_data = 32'd0; end
        endcase
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_write_nxt    = r_write;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_cnt_nxt      = r_cnt;
        w_seen_low_nxt = r_seen_low;
        w_done_nxt     = 1'b0;
        w_error_nxt    = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (cfg_valid) begin
                    w_state_nxt = c_st_wr_mode;
                    w_write_nxt = 1'b1;
                    w_addr_nxt  = w_tgt_addr;
                    w_data_nxt  = w_tgt_data;
                    w_load      = 1'b1;
                end
            end
            c_st_wr_mode, c_st_wr_n, c_st_wr_m, c_st_wr_k,
            c_st_wr_c0, c_st_wr_c1, c_st_wr_start: begin
                if (w_wr_cmpl) begin
                    w_state_nxt = w_seq_nxt;
                    if (w_seq_nxt == c_st_wait_lock) begin
                        w_write_nxt    = 1'b0;
                        w_cnt_nxt      = '0;
                        w_seen_low_nxt = 1'b0;
                    end else begin
                        w_write_nxt = 1'b1;
                        w_addr_nxt  = w_tgt_addr;
                        w_data_nxt  = w_tgt_data;
                    end
                end
            end
            c_st_wait_lock: begin
                w_cnt_nxt      = w_cnt_inc;
                w_seen_low_nxt = r_seen_low | ~r_lk_s;
                // A lock that never dropped is stale and must not count as relock.
                if (r_seen_low && r_lk_s) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = c_st_idle;
                end else if (w_cnt_inc == c_cnt_max) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_write_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_st_idle;
            r_lk_meta  <= 1'b0;
            r_lk_s     <= 1'b0;
            r_write    <= 1'b0;
            r_addr     <= 6'd0;
            r_data     <= 32'd0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_cnt      <= '0;
            r_seen_low <= 1'b0;
            r_n        <= 18'd0;
            r_m        <= 18'd0;
            r_k        <= 32'd0;
            r_c0       <= 18'd0;
            r_c1       <= 18'd0;
        end else begin
            r_lk_meta  <= pll_locked;
            r_lk_s     <= r_lk_meta;
            r_state    <= w_state_nxt;
            r_write    <= w_write_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_done     <= w_done_nxt;
            r_error    <= w_error_nxt;
            r_cnt      <= w_cnt_nxt;
            r_seen_low <= w_seen_low_nxt;
            if (w_load) begin
                r_n  <= cfg_n;
                r_m  <= cfg_m;
                r_k  <= cfg_k;
                r_c0 <= cfg_c0;
                r_c1 <= cfg_c1;
            end
        end
    end

    assign cfg_ready      = (r_state == c_st_idle) & ~rst;
    assign busy           = (r_state != c_st_idle);
    assign done           = r_done;
    assign error          = r_error;
    assign mgmt_write     = r_write;
    assign mgmt_address   = r_addr;
    assign mgmt_writedata = r_data;

endmodule
`default_nettype wire
